// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester IDs
// and the default bus widths of the RV32I core.
package dmem_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic ID_CORE = 1'b0;
   localparam logic ID_DMA  = 1'b1;

   typedef enum logic [1:0] {
      ST_RR         = 2'd0,
      ST_DMA_LOCK   = 2'd1,
      ST_FORCE_CORE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port signals of the data-memory arbiter.
// The slave view belongs to the arbiter; the master view to the requesters and memory.
interface dmem_arbiter_if import dmem_arbiter_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [3:0]        core_wstrb;
   logic              core_gnt;
   logic              core_rvalid;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [3:0]        dma_wstrb;
   logic              dma_lock;
   logic              dma_gnt;
   logic              dma_rvalid;

   logic [DATA_W-1:0] rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata, core_wstrb,
      output core_gnt, core_rvalid,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb, dma_lock,
      output dma_gnt, dma_rvalid, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata, core_wstrb,
      input  core_gnt, core_rvalid,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb, dma_lock,
      input  dma_gnt, dma_rvalid, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the
// requester that did not win last. gnt is one-hot, indexed by requester ID.
module dmem_rr_pick import dmem_arbiter_pkg::*; (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == ID_DMA) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core and the DMA port,
// with a bounded DMA burst lock and one-cycle read-data return.
module dmem_arbiter import dmem_arbiter_pkg::*; #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_LOCK = 8
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   arb_state_t       state, state_nxt;
   logic             last_gnt, last_nxt;
   logic [CNT_W-1:0] lock_cnt, cnt_nxt, cnt_new;
   logic             lock_step;
   logic [1:0]       req, pick_gnt, gnt;
   logic             core_fire, dma_fire;
   logic             core_rd_p1, dma_rd_p1;

   logic              en_mux, we_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic [3:0]        wstrb_mux;

   // requests are masked while reset is held so every combinational output is 0
   assign req = {bus.dma_req & rst, bus.core_req & rst};

   dmem_rr_pick u_pick (
      .req  (req),
      .last (last_gnt),
      .gnt  (pick_gnt)
   );

   always_comb begin
      gnt = pick_gnt;
      case (state)
         ST_DMA_LOCK:   if (req[ID_DMA])  gnt = 2'b10;
         ST_FORCE_CORE: if (req[ID_CORE]) gnt = 2'b01;
         default:       gnt = pick_gnt;
      endcase
   end

   assign core_fire = gnt[ID_CORE];
   assign dma_fire  = gnt[ID_DMA];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = lock_cnt;
      last_nxt  = last_gnt;
      cnt_new   = '0;
      lock_step = 1'b0;
      if (core_fire) last_nxt = ID_CORE;
      if (dma_fire)  last_nxt = ID_DMA;
      case (state)
         ST_RR: begin
            if (dma_fire && bus.dma_lock) begin
               cnt_new   = CNT_W'(1);
               lock_step = 1'b1;
            end
         end
         ST_DMA_LOCK: begin
            if (!req[ID_DMA] || !bus.dma_lock) begin
               state_nxt = ST_RR;
               cnt_nxt   = '0;
            end else begin
               cnt_new   = lock_cnt + CNT_W'(1);
               lock_step = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RR;
            cnt_nxt   = '0;
         end
      endcase
      // a locked beat that reaches the limit hands one slot to a waiting core
      if (lock_step) begin
         if (cnt_new == CNT_MAX) begin
            state_nxt = req[ID_CORE] ? ST_FORCE_CORE : ST_RR;
            cnt_nxt   = '0;
         end else begin
            state_nxt = ST_DMA_LOCK;
            cnt_nxt   = cnt_new;
         end
      end
   end

   always_comb begin
      en_mux    = 1'b0;
      we_mux    = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      wstrb_mux = '0;
      if (core_fire) begin
         en_mux    = 1'b1;
         we_mux    = bus.core_we;
         addr_mux  = bus.core_addr;
         wdata_mux = bus.core_wdata;
         wstrb_mux = bus.core_wstrb;
      end else if (dma_fire) begin
         en_mux    = 1'b1;
         we_mux    = bus.dma_we;
         addr_mux  = bus.dma_addr;
         wdata_mux = bus.dma_wdata;
         wstrb_mux = bus.dma_wstrb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_RR;
         last_gnt   <= ID_DMA;
         lock_cnt   <= '0;
         core_rd_p1 <= 1'b0;
         dma_rd_p1  <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_gnt   <= last_nxt;
         lock_cnt   <= cnt_nxt;
         core_rd_p1 <= core_fire & ~bus.core_we;
         dma_rd_p1  <= dma_fire & ~bus.dma_we;
      end
   end

   assign bus.core_gnt    = core_fire;
   assign bus.dma_gnt     = dma_fire;
   assign bus.core_rvalid = core_rd_p1;
   assign bus.dma_rvalid  = dma_rd_p1;
   assign bus.rdata       = bus.mem_rdata & {DATA_W{rst}};
   assign bus.mem_en      = en_mux;
   assign bus.mem_we      = we_mux;
   assign bus.mem_addr    = addr_mux;
   assign bus.mem_wdata   = wdata_mux;
   assign bus.mem_wstrb   = wstrb_mux;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port, synchronous-read data memory of the RV32I core between two requesters: the core load/store port and a DMA/loader port. It selects one access per cycle and drives the memory port. It returns read data one cycle later to whichever requester issued the read. A bounded DMA burst-lock mode lets bulk loads run back-to-back while still guaranteeing the core a slot. When `core_gnt` is low, the core stalls its PC.

Parameters:
ADDR_W, 32, byte address width on all ports
DATA_W, 32, data width
MAX_LOCK, 8, maximum consecutive DMA beats under lock before one core slot is forced (range 1..255)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core requests an access this cycle
core_we  in  1  1 = store, 0 = load
core_addr  in  ADDR_W  core byte address
core_wdata  in  DATA_W  core store data
core_wstrb  in  4  core byte enables (stores only)
core_gnt  out  1  core access accepted this cycle (combinational)
core_rvalid  out  1  core read data valid (registered pulse)
dma_req  in  1  DMA requests an access
dma_we  in  1  DMA store/load
dma_addr  in  ADDR_W  DMA byte address
dma_wdata  in  DATA_W  DMA store data
dma_wstrb  in  4  DMA byte enables
dma_lock  in  1  DMA requests burst lock; sampled on each DMA fire
dma_gnt  out  1  DMA access accepted (combinational)
dma_rvalid  out  1  DMA read data valid (registered pulse)
rdata  out  DATA_W  read data, shared by both requesters, qualified by the rvalid signals
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  4  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable

Behaviour:
- Fire rule: `X_req` && `X_gnt` in the same cycle. At most one grant is high in any cycle.
- Memory port is a combinational mux of the winning requester:
  - `mem_en` = any fire.
  - `mem_we` = winner's `we`.
  - When idle, all `mem_*` outputs are 0.
- Read return:
  - A read fire at cycle N gives `X_rvalid` = 1 in cycle N+1 only.
  - `rdata` = `mem_rdata` passed through combinationally.
  - Write fires produce no rvalid.
  - Back-to-back reads pipeline with no bubble.
- FSM states: RR, DMA_LOCK, FORCE_CORE. `last_gnt` register; `lock_cnt` of width clog2(MAX_LOCK+1).
- RR state:
  - Sole requester wins.
  - If both request, the one that was not `last_gnt` wins.
  - A DMA fire with `dma_lock` = 1 moves to DMA_LOCK with `lock_cnt` = 1.
- DMA_LOCK state:
  - Core is blocked while `dma_req` = 1.
  - Each DMA fire increments `lock_cnt`.
  - A DMA fire with `dma_lock` = 0 moves to RR.
  - A cycle with `dma_req` = 0 releases the lock: that cycle arbitrates as RR and the state moves to RR.
  - Reaching `lock_cnt` == MAX_LOCK on a fire moves to FORCE_CORE if `core_req` = 1, otherwise to RR.
- FORCE_CORE state:
  - DMA is blocked.
  - Core is granted if requesting; after one core fire, go to RR.
  - If `core_req` = 0, grant nothing to the core, apply RR arbitration that cycle, and go to RR.
- `last_gnt` updates on every fire. `lock_cnt` clears on leaving DMA_LOCK.
- Requester-side rules: `req` stays asserted with stable address/data until granted; address alignment is the requester's responsibility.
- Reset (asynchronous, active low):
  - State = RR, `last_gnt` = DMA (so the core wins the first tie), `lock_cnt` = 0.
  - Both rvalids = 0 and read-pending flags are cleared; a read in flight at reset is discarded (no rvalid after release).
  - All combinational outputs are 0 while `rst` = 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_RR, ST_DMA_LOCK, ST_FORCE_CORE).
  - Requester ID constants (ID_CORE = 0, ID_DMA = 1).
  - DATA_W/ADDR_W defaults matching the core.
- One natural sub-module, `dmem_rr_pick`: a combinational two-way round-robin picker with inputs `req[1:0]` and `last`, output one-hot `gnt`. FSM, counter and read tracking stay in the top.

Test Plan:
1. Core only: core read of addr 100 with memory returning 25 -> `core_gnt` = 1 in the same cycle, `core_rvalid` = 1 and `rdata` = 25 next cycle, `dma_rvalid` = 0.
2. Tie after reset: both request in cycle 0 -> core granted in cycle 0, DMA in cycle 1, core in cycle 2 (alternating).
3. Lock with MAX_LOCK = 4: DMA streams writes with `dma_lock` = 1 while the core requests continuously -> 4 DMA fires, then 1 core fire, then DMA resumes (the fifth DMA beat re-enters DMA_LOCK).
4. Lock release: DMA drops `dma_req` after 2 locked beats -> the core is granted in that same cycle, state returns to RR, `lock_cnt` = 0.
5. Pipelined reads: core read at N, DMA read at N+1 -> `core_rvalid` at N+1 and `dma_rvalid` at N+2, each with the correct data.
6. Reset mid-read: assert `rst` = 0 in the cycle after a core read fire -> `core_rvalid` stays 0, all outputs are 0, and after release the first tie goes to the core.
